// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares the single-port rv_ram data memory between instruction fetch (m0)
//   and the load/store unit (m1). One command is latched per grant and held on
//   the RAM port until the RAM answers (or the watchdog fires). The response is
//   routed to the owning master. ram_req_o then drops for one GAP cycle so the
//   RAM latency pipeline drains. Ties are broken round-robin.
//
// Ports
//   clk_i, arstn_i            clock (rising edge), asynchronous active-low reset
//   mN_req_i                  request, held with a stable command until mN_gnt_o
//   mN_we_i/be_i/addr_i/wdata_i  command fields
//   mN_gnt_o                  one-cycle pulse: command latched
//   mN_rvalid_o               one-cycle pulse: response for master N
//   mN_rdata_o, mN_err_o      response data / timeout flag, zero unless rvalid
//   ram_req_o .. ram_wdata_o  command towards the RAM (zero outside BUSY)
//   ram_rvalid_i, ram_rdata_i response from the RAM
module rv_mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_be_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_be_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m1_rdata_o,
  output logic              m1_err_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [XLEN/8-1:0] ram_be_o,
  output logic [XLEN-1:0]   ram_addr_o,
  output logic [XLEN-1:0]   ram_wdata_o,
  input  logic              ram_rvalid_i,
  input  logic [XLEN-1:0]   ram_rdata_i
);

  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;    // master granted most recently
  logic              owner_q, owner_d;  // master owning the transaction in flight
  logic [CW-1:0]     cnt_q, cnt_d;

  // Latched command doubles as the RAM-side output registers.
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [BW-1:0]     be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [XLEN-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;

  logic              sel;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rd0_d   = '0;
    rd1_d   = '0;
    // On a tie the master that did not win last time gets the slot.
    sel     = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;

    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (m0_req_i || m1_req_i) begin
          owner_d = sel;
          last_d  = sel;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = BUSY;
          if (sel) begin
            gnt1_d  = 1'b1;
            we_d    = m1_we_i;
            be_d    = m1_be_i;
            addr_d  = m1_addr_i;
            wdata_d = m1_wdata_i;
          end else begin
            gnt0_d  = 1'b1;
            we_d    = m0_we_i;
            be_d    = m0_be_i;
            addr_d  = m0_addr_i;
            wdata_d = m0_wdata_i;
          end
        end
      end
      BUSY: begin
        if (ram_rvalid_i || (cnt_q == CW'(TIMEOUT - 1))) begin
          // Response (real or forced by the watchdog) goes to the owner only.
          if (owner_q) begin
            rv1_d  = 1'b1;
            err1_d = ~ram_rvalid_i;
            rd1_d  = ram_rvalid_i ? ram_rdata_i : '0;
          end else begin
            rv0_d  = 1'b1;
            err0_d = ~ram_rvalid_i;
            rd0_d  = ram_rvalid_i ? ram_rdata_i : '0;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        // The RAM may emit one stale rvalid here; it is deliberately ignored.
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign m0_gnt_o    = gnt0_q;
  assign m1_gnt_o    = gnt1_q;
  assign m0_rvalid_o = rv0_q;
  assign m1_rvalid_o = rv1_q;
  assign m0_err_o    = err0_q;
  assign m1_err_o    = err1_q;
  assign m0_rdata_o  = rd0_q;
  assign m1_rdata_o  = rd1_q;
  assign ram_req_o   = req_q;
  assign ram_we_o    = we_q;
  assign ram_be_o    = be_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [3:0]  m0_be_i = '0;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]  m1_be_i = '0;
  logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  rv_mem_arbiter #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
  );

  // RAM stub, LATENCY=3: accepts a request, answers 3 edges later, then emits
  // one stale pulse in the following cycle. It accepts again only after
  // ram_req_o has been low. mute suppresses answers; spur injects a pulse.
  logic [31:0] mem [0:63];
  logic        mute = 1'b0, spur = 1'b0;
  logic        st_busy, st_armed, st_stale, stub_rv;
  logic [1:0]  st_cnt;
  logic [31:0] st_rdata, stub_rd;

  assign ram_rvalid_i = stub_rv | spur;
  assign ram_rdata_i  = stub_rd;

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      st_busy  <= 1'b0;
      st_armed <= 1'b1;
      st_stale <= 1'b0;
      st_cnt   <= '0;
      stub_rv  <= 1'b0;
      stub_rd  <= '0;
      st_rdata <= '0;
      mem[4]   <= 32'hDEADBEEF;
      mem[8]   <= 32'hAABBCCDD;
    end else begin
      stub_rv <= 1'b0;
      stub_rd <= '0;
      if (st_stale) begin
        stub_rv  <= 1'b1;
        stub_rd  <= 32'hBAD0BAD0;
        st_stale <= 1'b0;
      end
      if (!ram_req_o) st_armed <= 1'b1;
      if (st_busy) begin
        if (st_cnt == 2'd2) begin
          st_busy <= 1'b0;
          if (!mute) begin
            stub_rv  <= 1'b1;
            stub_rd  <= st_rdata;
            st_stale <= 1'b1;
          end
        end else begin
          st_cnt <= st_cnt + 2'd1;
        end
      end else if (ram_req_o && st_armed) begin
        st_busy  <= 1'b1;
        st_armed <= 1'b0;
        st_cnt   <= '0;
        st_rdata <= mem[ram_addr_o[7:2]];
        if (ram_we_o)
          for (int b = 0; b < 4; b++)
            if (ram_be_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic r, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_req_i = r; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wd;
    end else begin
      m1_req_i = r; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wd;
    end
  endtask

  // One transaction from master m; latencies counted in cycles from the
  // request cycle to gnt, and from gnt to rvalid.
  task automatic txn(input string tag, input int m, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd, input logic chk_rd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int n;
    logic g, rv;
    @(negedge clk_i);
    set_req(m, 1'b1, we, be, addr, wd);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      g = (m == 0) ? m0_gnt_o : m1_gnt_o;
    end while (!g && n < 20);
    chk({tag, " gnt_lat"}, n, 1);
    chk({tag, " other_gnt"}, (m == 0) ? m1_gnt_o : m0_gnt_o, 0);
    chk({tag, " ram_req"}, ram_req_o, 1);
    set_req(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      rv = (m == 0) ? m0_rvalid_o : m1_rvalid_o;
    end while (!rv && n < 40);
    chk({tag, " rv_lat"}, n, exp_lat);
    chk({tag, " err"}, (m == 0) ? m0_err_o : m1_err_o, exp_err);
    if (chk_rd) chk({tag, " rdata"}, (m == 0) ? m0_rdata_o : m1_rdata_o, exp_rd);
    chk({tag, " other_rv"}, (m == 0) ? m1_rvalid_o : m0_rvalid_o, 0);
    chk({tag, " other_rdata"}, (m == 0) ? m1_rdata_o : m0_rdata_o, 0);
    chk({tag, " gap_req"}, ram_req_o, 0);
    @(negedge clk_i);
    chk({tag, " gap_no_rv"}, {m0_rvalid_o, m1_rvalid_o}, 0);
    chk({tag, " gap_req2"}, ram_req_o, 0);
  endtask

  initial begin
    int gm[4];
    int gc[4];
    int ng, nr, seen;
    int last_owner;

    // Reset state
    #2;
    chk("rst ram_req", ram_req_o, 0);
    chk("rst gnt", {m0_gnt_o, m1_gnt_o}, 0);
    chk("rst rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    chk("rst ram_addr", ram_addr_o, 0);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;

    // 1: m0 read of 0x10
    txn("t1", 0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 5);

    // 2: m1 partial write then read back
    txn("t2w", 1, 1'b1, 4'b0101, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b0, 5);
    txn("t2r", 1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'hAA22CC44, 1'b0, 5);

    // 3: both masters requesting continuously -> alternating grants, 7 cycles apart
    @(negedge clk_i);
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    ng = 0; nr = 0; last_owner = -1;
    for (int c = 1; c <= 60 && nr < 4; c++) begin
      @(negedge clk_i);
      if (m0_gnt_o && m1_gnt_o) chk("t3 both_gnt", 1, 0);
      if (m0_rvalid_o && m1_rvalid_o) chk("t3 both_rv", 1, 0);
      if ((m0_gnt_o || m1_gnt_o) && ng < 4) begin
        gm[ng] = m1_gnt_o ? 1 : 0;
        gc[ng] = c;
        last_owner = gm[ng];
        ng++;
        if (ng == 4) begin
          set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
          set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
      end
      if (m0_rvalid_o || m1_rvalid_o) begin
        nr++;
        chk("t3 rv_owner", m1_rvalid_o, last_owner);
        chk("t3 rdata", m1_rvalid_o ? m1_rdata_o : m0_rdata_o,
            m1_rvalid_o ? 32'hAA22CC44 : 32'hDEADBEEF);
        chk("t3 gap_req", ram_req_o, 0);
      end
    end
    chk("t3 ngrants", ng, 4);
    chk("t3 nresp", nr, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        chk($sformatf("t3 g%0d master", i), gm[i], i % 2);
        chk($sformatf("t3 g%0d cycle", i), gc[i], 1 + 7 * i);
      end
    end
    repeat (3) @(negedge clk_i);

    // 4: RAM silent -> watchdog error response, then normal operation resumes
    mute = 1'b1;
    txn("t4to", 0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 16);
    mute = 1'b0;
    txn("t4ok", 0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 5);

    // 5: reset during an m0 transaction
    @(negedge clk_i);
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk_i);
    chk("t5 gnt", m0_gnt_o, 1);
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    chk("t5 busy_req", ram_req_o, 1);
    arstn_i = 1'b0;
    #1;
    chk("t5 rst ram_req", ram_req_o, 0);
    chk("t5 rst ram_addr", ram_addr_o, 0);
    chk("t5 rst rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (m0_rvalid_o || m1_rvalid_o || ram_req_o) seen++;
    end
    chk("t5 no_resp", seen, 0);
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk_i);
    chk("t5 tie gnt", {m0_gnt_o, m1_gnt_o}, 2'b10);
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (m0_rvalid_o) seen++;
    end
    chk("t5 tie resp", seen, 1);

    // 6: spurious rvalid while IDLE is ignored
    @(negedge clk_i);
    spur = 1'b1;
    @(negedge clk_i);
    spur = 1'b0;
    chk("t6 spur rv", {m0_rvalid_o, m1_rvalid_o}, 0);
    @(negedge clk_i);
    chk("t6 spur rv2", {m0_rvalid_o, m1_rvalid_o}, 0);
    txn("t6ok", 1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
